// File: rtl/ec_ctrl_pkg.sv
// Shared definitions for the erasure-coding engine job controller:
// state encoding, default timing parameters and the configuration legality check.
package ec_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        DONE
    } state_t;

    localparam int PIPE_LAT_DEF      = 3;
    localparam int PACKET_LENGTH_DEF = 2;

    // A job is rejected when it has no packets or a parity count outside [m_min, m_max].
    function automatic logic cfg_illegal(input int unsigned num_pkts,
                                         input int unsigned m,
                                         input int unsigned m_min,
                                         input int unsigned m_max);
        return (num_pkts == 0) || (m < m_min) || (m > m_max);
    endfunction

endpackage

// File: rtl/ec_engine_ctrl_inflight.sv
// ec_inflight_tracker: follows beats through the engine pipeline so the output
// buffer write strobe appears exactly PIPE_LAT cycles after each issue.
module ec_inflight_tracker
    import ec_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic issue,
    output logic valid,
    output logic empty
);

    logic [PIPE_LAT-1:0] sr;
    logic [PIPE_LAT-1:0] remaining;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | PIPE_LAT'(issue);
        end
    end

    // Beats still in flight once the one leaving this cycle has been written out.
    assign remaining = sr << 1;
    assign empty     = (remaining == '0);
    assign valid     = sr[PIPE_LAT-1];

endmodule

// File: rtl/ec_engine_ctrl.sv
// ec_engine_ctrl: job-level sequencer for one erasure-coding encode job.
// Optional macro ENGINE_CTRL_PERF_EN adds perf_cycles / perf_stalls counters.
module ec_engine_ctrl
    import ec_ctrl_pkg::*;
#(
    parameter int K_MAX         = 128,
    parameter int M_MAX         = 128,
    parameter int M_MIN         = 2,
    parameter int PACKET_LENGTH = PACKET_LENGTH_DEF,
    parameter int PIPE_LAT      = PIPE_LAT_DEF,
    parameter int PKT_CNT_W     = 16,
    parameter int MREG_W        = $clog2(M_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PKT_CNT_W-1:0] num_pkts,
    input  logic [MREG_W-1:0]    m_reg,
    input  logic                 inbuff_empty,
    input  logic                 outbuff_afull,
    output logic                 eng_rstn,
    output logic                 cfg_wr_en,
    output logic                 inbuff_rd_en,
    output logic                 bm_rd_en,
    output logic                 calc_en,
    output logic                 outbuff_wr_en,
    output logic [M_MAX-1:0]     ch_en,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 cfg_err
`ifdef ENGINE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int BEAT_W = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;

    if (PACKET_LENGTH < 1 || PIPE_LAT < 1 || K_MAX < 1 || M_MIN > M_MAX) begin : g_bad_params
        $error("ec_engine_ctrl: illegal parameter set");
    end

    state_t               state;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic [PKT_CNT_W-1:0] last_pkt;
    logic                 issue;
    logic                 clear_inflight;
    logic                 inflight_empty;

    function automatic logic [M_MAX-1:0] channel_mask(input logic [MREG_W-1:0] m);
        logic [M_MAX-1:0] mask;
        for (int i = 0; i < M_MAX; i++) mask[i] = (i < int'(m));
        return mask;
    endfunction

    // Issue is combinational so the buffers see the read strobe in the cycle the flags allow it.
    assign issue          = (state == CALC) && !inbuff_empty && !outbuff_afull;
    assign inbuff_rd_en   = issue;
    assign bm_rd_en       = issue;
    assign calc_en        = issue;
    assign clear_inflight = abort && (state != IDLE);

    ec_inflight_tracker #(
        .PIPE_LAT (PIPE_LAT)
    ) u_inflight (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear_inflight),
        .issue (issue),
        .valid (outbuff_wr_en),
        .empty (inflight_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            last_pkt  <= '0;
            eng_rstn  <= 1'b0;
            cfg_wr_en <= 1'b0;
            ch_en     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the branch that fires raises them.
            cfg_wr_en <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;

            if (abort && state != IDLE) begin
                state    <= IDLE;
                aborted  <= 1'b1;
                eng_rstn <= 1'b0;
                busy     <= 1'b0;
                ch_en    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_illegal(32'(num_pkts), 32'(m_reg), M_MIN, M_MAX)) begin
                                cfg_err <= 1'b1;
                            end else begin
                                state     <= LOAD;
                                cfg_wr_en <= 1'b1;
                                eng_rstn  <= 1'b1;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state    <= CALC;
                        last_pkt <= num_pkts - PKT_CNT_W'(1);
                        beat_cnt <= '0;
                        pkt_cnt  <= '0;
                        ch_en    <= channel_mask(m_reg);
                    end
                    CALC: begin
                        if (issue) begin
                            if (beat_cnt == BEAT_W'(PACKET_LENGTH - 1)) begin
                                beat_cnt <= '0;
                                if (pkt_cnt == last_pkt) state <= DRAIN;
                                else                     pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                            end else begin
                                beat_cnt <= beat_cnt + BEAT_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (inflight_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        eng_rstn <= 1'b0;
                        busy     <= 1'b0;
                        ch_en    <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ENGINE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == LOAD) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == CALC || state == DRAIN) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (state == CALC && !issue && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ec_engine_ctrl.sv
// Self-checking bench for ec_engine_ctrl: a job-level reference model checked every
// cycle, plus hand-computed latency / count expectations for directed jobs.
module tb_ec_engine_ctrl;

    localparam int PL    = 2;
    localparam int PLAT  = 3;
    localparam int MMAX  = 128;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         abort;
    logic [15:0]  num_pkts;
    logic [7:0]   m_reg;
    logic         inbuff_empty;
    logic         outbuff_afull;
    logic         eng_rstn;
    logic         cfg_wr_en;
    logic         inbuff_rd_en;
    logic         bm_rd_en;
    logic         calc_en;
    logic         outbuff_wr_en;
    logic [127:0] ch_en;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         cfg_err;
`ifdef ENGINE_CTRL_PERF_EN
    logic [31:0]  perf_cycles;
    logic [31:0]  perf_stalls;
`endif

    ec_engine_ctrl #(
        .K_MAX(128), .M_MAX(MMAX), .M_MIN(2), .PACKET_LENGTH(PL), .PIPE_LAT(PLAT), .PKT_CNT_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_pkts(num_pkts), .m_reg(m_reg),
        .inbuff_empty(inbuff_empty), .outbuff_afull(outbuff_afull), .eng_rstn(eng_rstn),
        .cfg_wr_en(cfg_wr_en), .inbuff_rd_en(inbuff_rd_en), .bm_rd_en(bm_rd_en), .calc_en(calc_en),
        .outbuff_wr_en(outbuff_wr_en), .ch_en(ch_en), .busy(busy), .done(done),
        .aborted(aborted), .cfg_err(cfg_err)
`ifdef ENGINE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observed DUT activity, used by the hand-computed expectations.
    int n_issue = 0, n_wr = 0, n_done = 0, n_ab = 0, n_ce = 0, n_cw = 0;
    int n_issue_hold = 0, n_wr_hold = 0, done_cyc = 0, ab_cyc = 0;
    logic [127:0] done_ch = '0;

    // Job-level reference: beats remaining, a queue of write-back due cycles, and the channel mask.
    typedef enum int {M_IDLE, M_LOAD, M_CALC, M_DRAIN, M_DONE} mph_t;
    mph_t         ph = M_IDLE;
    int           beats_left = 0;
    int           wb_q[$];
    logic [127:0] exp_mask = '0;
    bit           pend_ab = 1'b0;
    bit           pend_ce = 1'b0;

    always @(negedge clk) begin : model
        bit           e_issue;
        bit           e_wr;
        logic [127:0] e_ch;
        if (!rstn) begin
            ph = M_IDLE;
            wb_q.delete();
            pend_ab = 1'b0;
            pend_ce = 1'b0;
            exp_mask = '0;
        end
        e_issue = (ph == M_CALC) && !inbuff_empty && !outbuff_afull;
        e_wr    = (wb_q.size() > 0) && (wb_q[0] == cyc);
        e_ch    = (ph == M_CALC || ph == M_DRAIN || ph == M_DONE) ? exp_mask : '0;
        check("busy",          busy,          (ph != M_IDLE));
        check("eng_rstn",      eng_rstn,      (ph != M_IDLE));
        check("cfg_wr_en",     cfg_wr_en,     (ph == M_LOAD));
        check("inbuff_rd_en",  inbuff_rd_en,  e_issue);
        check("bm_rd_en",      bm_rd_en,      e_issue);
        check("calc_en",       calc_en,       e_issue);
        check("outbuff_wr_en", outbuff_wr_en, e_wr);
        check("done",          done,          (ph == M_DONE));
        check("aborted",       aborted,       pend_ab);
        check("cfg_err",       cfg_err,       pend_ce);
        check("ch_en",         ch_en,         e_ch);

        if (inbuff_rd_en) n_issue++;
        if (outbuff_wr_en) n_wr++;
        if (outbuff_afull && inbuff_rd_en) n_issue_hold++;
        if (outbuff_afull && outbuff_wr_en) n_wr_hold++;
        if (done) begin n_done++; done_cyc = cyc; done_ch = ch_en; end
        if (aborted) begin n_ab++; ab_cyc = cyc; end
        if (cfg_err) n_ce++;
        if (cfg_wr_en) n_cw++;

        if (rstn) begin
            if (e_wr) void'(wb_q.pop_front());
            pend_ab = 1'b0;
            pend_ce = 1'b0;
            if (abort && ph != M_IDLE) begin
                ph = M_IDLE;
                pend_ab = 1'b1;
                wb_q.delete();
            end else begin
                case (ph)
                    M_IDLE: if (start) begin
                        if (num_pkts == 0 || m_reg < 2 || m_reg > MMAX) pend_ce = 1'b1;
                        else ph = M_LOAD;
                    end
                    M_LOAD: begin
                        beats_left = int'(num_pkts) * PL;
                        exp_mask = (m_reg >= MMAX) ? {128{1'b1}} : ((128'd1 << m_reg) - 128'd1);
                        ph = M_CALC;
                    end
                    M_CALC: if (e_issue) begin
                        wb_q.push_back(cyc + PLAT);
                        beats_left--;
                        if (beats_left == 0) ph = M_DRAIN;
                    end
                    M_DRAIN: if (wb_q.size() == 0) ph = M_DONE;
                    M_DONE:  ph = M_IDLE;
                    default: ph = M_IDLE;
                endcase
            end
        end
    end

    // mode 0: free-running, 1: inbuff_empty every other cycle, 2: afull hold, 3: abort
    task automatic run_job(input int n, input int m, input int mode, output int t_s);
        int d0;
        bit fin;
        d0  = n_done;
        fin = 1'b0;
        @(posedge clk); #1;
        num_pkts = 16'(n);
        m_reg    = 8'(m);
        start    = 1'b1;
        t_s      = cyc;
        for (int i = 1; i <= 60 && !fin; i++) begin
            @(posedge clk); #1;
            start         = 1'b0;
            inbuff_empty  = (mode == 1) ? (i % 2 == 1) : (mode == 3 && i == 4);
            outbuff_afull = (mode == 2) && (i >= 4) && (i <= 8);
            abort         = (mode == 3) && (i == 4);
            @(negedge clk); #1;
            if (mode == 3) fin = (i >= 14);
            else           fin = (n_done != d0);
        end
        inbuff_empty  = 1'b0;
        outbuff_afull = 1'b0;
        abort         = 1'b0;
        if (mode != 3) check("job_done_seen", 32'(n_done - d0), 32'd1);
    endtask

    task automatic pulse_start(input int n, input int m, input bit with_abort);
        @(posedge clk); #1;
        num_pkts = 16'(n);
        m_reg    = 8'(m);
        start    = !with_abort;
        abort    = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t_s, i0, w0, d0, a0, c0, cw0;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; num_pkts = '0; m_reg = '0;
        inbuff_empty = 1'b0; outbuff_afull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_ch_en", ch_en, '0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Baseline job: 3 packets x 2 beats, no stalls.
        i0 = n_issue; w0 = n_wr;
        run_job(3, 4, 0, t_s);
        check("t1_latency", 32'(done_cyc - t_s), 32'd11);
        check("t1_issues", 32'(n_issue - i0), 32'd6);
        check("t1_writes", 32'(n_wr - w0), 32'd6);
        check("t1_ch_en", done_ch, 128'hF);

        // Input buffer empty on alternate cycles.
        i0 = n_issue;
        run_job(3, 4, 1, t_s);
        check("t2_latency", 32'(done_cyc - t_s), 32'd16);
        check("t2_issues", 32'(n_issue - i0), 32'd6);

        // Output buffer almost-full for five cycles mid-job.
        w0 = n_wr; n_issue_hold = 0; n_wr_hold = 0;
        run_job(3, 4, 2, t_s);
        check("t3_latency", 32'(done_cyc - t_s), 32'd16);
        check("t3_hold_issues", 32'(n_issue_hold), 32'd0);
        check("t3_hold_writes", 32'(n_wr_hold), 32'd2);
        check("t3_writes", 32'(n_wr - w0), 32'd6);

        // Abort two cycles after the first issue.
        w0 = n_wr; d0 = n_done; a0 = n_ab;
        run_job(3, 4, 3, t_s);
        check("t4_abort_cycle", 32'(ab_cyc - t_s), 32'd5);
        check("t4_abort_count", 32'(n_ab - a0), 32'd1);
        check("t4_no_writes", 32'(n_wr - w0), 32'd0);
        check("t4_no_done", 32'(n_done - d0), 32'd0);
        check("t4_eng_rstn", eng_rstn, 1'b0);

        // Illegal configurations and abort while idle.
        c0 = n_ce; cw0 = n_cw; a0 = n_ab;
        pulse_start(3, 1, 1'b0);
        pulse_start(0, 4, 1'b0);
        pulse_start(3, 129, 1'b0);
        pulse_start(3, 4, 1'b1);
        check("t5_cfg_err", 32'(n_ce - c0), 32'd3);
        check("t5_no_cfg_wr", 32'(n_cw - cw0), 32'd0);
        check("t5_idle_abort", 32'(n_ab - a0), 32'd0);

        // Parity-count boundaries with a single-packet job.
        run_job(1, 2, 0, t_s);
        check("t6_latency", 32'(done_cyc - t_s), 32'd7);
        check("t6_ch_min", done_ch, 128'h3);
        run_job(1, 128, 0, t_s);
        check("t6_ch_max", done_ch, {128{1'b1}});

        // Asynchronous reset in the middle of CALC, then a clean job.
        @(posedge clk); #1;
        num_pkts = 16'd3; m_reg = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("t7_busy", busy, 1'b0);
        check("t7_eng_rstn", eng_rstn, 1'b0);
        check("t7_issue", {inbuff_rd_en, bm_rd_en, calc_en}, 3'b000);
        check("t7_ch_en", ch_en, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        i0 = n_issue;
        run_job(3, 4, 0, t_s);
        check("t7_latency", 32'(done_cyc - t_s), 32'd11);
        check("t7_issues", 32'(n_issue - i0), 32'd6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ec_engine_ctrl.md
# ec_engine_ctrl

Parametrised job-level control FSM for the erasure-coding engine: it sequences configuration latch, beat issue, pipeline drain and completion for one encode job of a programmed packet count. It sits between the control registers / host start logic and the input buffer, bitmatrix memory, engine datapath and output buffer. Unlike the previous single-level controller, it counts beats and packets, tracks in-flight beats through a PIPE_LAT-deep engine pipeline, applies buffer back-pressure, supports abort and drives per-parity-channel enables.

## Interface
- K_MAX, 128, max data chunks
- M_MAX, 128, max parity chunks; also number of parity channels driven by ch_en
- M_MIN, 2, min legal parity count
- PACKET_LENGTH, 2, beats per packet (>=1)
- PIPE_LAT, 3, cycles from beat issue to engine output valid (>=1)
- PKT_CNT_W, 16, width of packet count
- MREG_W, $clog2(M_MAX+1), width of m_reg
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  job start request (level sampled in IDLE)
- abort  in  1  abort current job
- num_pkts  in  PKT_CNT_W  packets in job
- m_reg  in  MREG_W  active parity count
- inbuff_empty  in  1  input buffer has no beat
- outbuff_afull  in  1  output buffer has < PIPE_LAT+1 free entries
- eng_rstn  out  1  engine datapath reset, active-low
- cfg_wr_en  out  1  latch control registers
- inbuff_rd_en, bm_rd_en, calc_en  out  1  beat issue strobes (identical)
- outbuff_wr_en  out  1  engine output valid, write output buffer
- ch_en  out  M_MAX  ch_en[i]=1 iff i < latched m_reg
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse
- aborted  out  1  one-cycle abort pulse
- cfg_err  out  1  one-cycle illegal-config pulse

## Operation
- States: IDLE, LOAD, CALC, DRAIN, DONE.
- IDLE: eng_rstn=0. start=1 with num_pkts!=0 and M_MIN<=m_reg<=M_MAX -> LOAD; start with illegal config -> cfg_err pulse, stay IDLE.
- LOAD (1 cycle): cfg_wr_en=1, eng_rstn=1; latch num_pkts, m_reg; clear beat/packet counters -> CALC.
- CALC: issue = !inbuff_empty & !outbuff_afull; issue drives inbuff_rd_en/bm_rd_en/calc_en same cycle. Beat counter 0..PACKET_LENGTH-1 wraps; packet counter increments on wrap. Issue of final beat of packet num_pkts-1 -> DRAIN.
- DRAIN: no issue; -> DONE when in-flight shift register is empty.
- DONE (1 cycle): done=1 -> IDLE.
- In-flight tracking: PIPE_LAT-bit shift register fed by issue; outbuff_wr_en = its output bit.
- abort (any non-IDLE state) -> IDLE next cycle, aborted=1 that cycle, shift register cleared, no done, no further outbuff_wr_en. abort in IDLE ignored; abort has priority over all transitions.
- start while busy ignored. ch_en held from latched m_reg, cleared in IDLE.

## Timing
- Reset: state IDLE; all outputs 0 (eng_rstn=0, ch_en=0); counters and shift register 0.
- Issue strobes combinational from state and flags, same cycle.
- outbuff_wr_en registered: beat issued in cycle t -> outbuff_wr_en in cycle t+PIPE_LAT.
- done/aborted/cfg_err registered, exactly one cycle.
- Minimum job: start at t -> LOAD t+1 -> first issue t+2 -> done at t+2+N*PACKET_LENGTH+PIPE_LAT with no stalls (N=num_pkts).
- Counters: packet counter PKT_CNT_W bits, compare against latched num_pkts-1; no wrap within a legal job.

## Configuration
- ENGINE_CTRL_PERF_EN defined: adds outputs perf_cycles[31:0] (cycles in CALC+DRAIN) and perf_stalls[31:0] (CALC cycles without issue); both cleared in LOAD, held after DONE, saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package ec_ctrl_pkg: state enum, PIPE_LAT/PACKET_LENGTH defaults, illegal-config check function.
- Sub-module ec_inflight_tracker: PIPE_LAT shift register with clear, empty flag and valid output.

## Test plan
- num_pkts=3, PACKET_LENGTH=2, m_reg=4, no stalls -> 6 issue strobes on consecutive cycles, 6 outbuff_wr_en PIPE_LAT later, done at start+2+6+3, ch_en=0b1111.
- inbuff_empty toggled every other cycle in CALC -> issues only when low, total issues still 6, done delayed accordingly.
- outbuff_afull held 5 cycles mid-job -> zero issues during hold, in-flight beats still write out, no beat lost.
- abort 2 cycles after first issue -> aborted pulse, IDLE next cycle, eng_rstn=0, no further outbuff_wr_en, no done.
- start with m_reg=1 or num_pkts=0 -> cfg_err pulse, busy stays 0, cfg_wr_en never asserted.
- rstn asserted mid-CALC -> all outputs 0 immediately; after release, new start runs full job correctly.
